// File: rtl/bcd_timekeeper.sv
// BCD hh:mm:ss timekeeper with a seconds prescaler, field adjust pulses and a palette rotation index.
// Defining TIMEKEEPER_12H_EN makes hours run 1..12; otherwise they run 00..23.
module bcd_timekeeper #(
  parameter int TICKS_PER_SEC = 31_500_000
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       adj_sec_pulse,
  input  logic       adj_min_pulse,
  input  logic       adj_hrs_pulse,
  output logic [3:0] sec_u,
  output logic [2:0] sec_d,
  output logic [3:0] min_u,
  output logic [2:0] min_d,
  output logic [3:0] hrs_u,
  output logic [1:0] hrs_d,
  output logic [3:0] color_offset,
  output logic       sec_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

`ifdef TIMEKEEPER_12H_EN
  localparam logic [1:0] HRS_D_RST = 2'd1;
  localparam logic [3:0] HRS_U_RST = 4'd2;
`else
  localparam logic [1:0] HRS_D_RST = 2'd0;
  localparam logic [3:0] HRS_U_RST = 4'd0;
`endif

  logic [PW-1:0] presc;
  logic          pending;
  logic          tick;
  logic          adj_any;
  logic          apply_tick;

  logic [3:0] sec_u_nx;
  logic [2:0] sec_d_nx;
  logic [3:0] min_u_nx;
  logic [2:0] min_d_nx;
  logic [3:0] hrs_u_nx;
  logic [1:0] hrs_d_nx;
  logic       sec_wrap;
  logic       min_wrap;

  assign tick    = (presc == PRESC_LAST);
  assign adj_any = adj_sec_pulse | adj_min_pulse | adj_hrs_pulse;
  // Any adjust pulse defers the tick; a tick that lands while one already waits merges into it.
  assign apply_tick = (tick | pending) & ~adj_any;

  assign sec_wrap = (sec_u == 4'd9) && (sec_d == 3'd5);
  assign min_wrap = (min_u == 4'd9) && (min_d == 3'd5);

  always_comb begin
    sec_u_nx = sec_u + 4'd1;
    sec_d_nx = sec_d;
    if (sec_u == 4'd9) begin
      sec_u_nx = 4'd0;
      sec_d_nx = (sec_d == 3'd5) ? 3'd0 : sec_d + 3'd1;
    end
  end

  always_comb begin
    min_u_nx = min_u + 4'd1;
    min_d_nx = min_d;
    if (min_u == 4'd9) begin
      min_u_nx = 4'd0;
      min_d_nx = (min_d == 3'd5) ? 3'd0 : min_d + 3'd1;
    end
  end

  always_comb begin
    hrs_u_nx = hrs_u + 4'd1;
    hrs_d_nx = hrs_d;
`ifdef TIMEKEEPER_12H_EN
    if (hrs_d == 2'd1 && hrs_u == 4'd2) begin
      hrs_d_nx = 2'd0;
      hrs_u_nx = 4'd1;
    end else if (hrs_u == 4'd9) begin
      hrs_d_nx = 2'd1;
      hrs_u_nx = 4'd0;
    end
`else
    if (hrs_d == 2'd2 && hrs_u == 4'd3) begin
      hrs_d_nx = 2'd0;
      hrs_u_nx = 4'd0;
    end else if (hrs_u == 4'd9) begin
      hrs_d_nx = hrs_d + 2'd1;
      hrs_u_nx = 4'd0;
    end
`endif
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      presc        <= '0;
      pending      <= 1'b0;
      sec_tick     <= 1'b0;
      color_offset <= 4'd0;
      sec_u        <= 4'd0;
      sec_d        <= 3'd0;
      min_u        <= 4'd0;
      min_d        <= 3'd0;
      hrs_u        <= HRS_U_RST;
      hrs_d        <= HRS_D_RST;
    end else begin
      presc    <= tick ? '0 : presc + PW'(1);
      pending  <= adj_any & (tick | pending);
      sec_tick <= apply_tick;
      if (apply_tick) begin
        sec_u <= sec_u_nx;
        sec_d <= sec_d_nx;
        if (sec_wrap) begin
          min_u        <= min_u_nx;
          min_d        <= min_d_nx;
          color_offset <= color_offset + 4'd1;
          if (min_wrap) begin
            hrs_u <= hrs_u_nx;
            hrs_d <= hrs_d_nx;
          end
        end
      end else begin
        // Adjusts touch only their own field; no carry between fields.
        if (adj_sec_pulse) begin
          sec_u <= sec_u_nx;
          sec_d <= sec_d_nx;
        end
        if (adj_min_pulse) begin
          min_u        <= min_u_nx;
          min_d        <= min_d_nx;
          color_offset <= color_offset + 4'd1;
        end
        if (adj_hrs_pulse) begin
          hrs_u <= hrs_u_nx;
          hrs_d <= hrs_d_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed and randomized checks of bcd_timekeeper (TICKS_PER_SEC=4) against an integer-time model.
module tb_bcd_timekeeper;

  localparam int T = 4;

  logic       px_clk = 1'b0;
  logic       reset = 1'b1;
  logic       adj_sec_pulse = 1'b0;
  logic       adj_min_pulse = 1'b0;
  logic       adj_hrs_pulse = 1'b0;
  logic [3:0] sec_u;
  logic [2:0] sec_d;
  logic [3:0] min_u;
  logic [2:0] min_d;
  logic [3:0] hrs_u;
  logic [1:0] hrs_d;
  logic [3:0] color_offset;
  logic       sec_tick;

  int checks = 0;
  int failures = 0;

  bcd_timekeeper #(.TICKS_PER_SEC(T)) dut (
    .px_clk(px_clk), .reset(reset),
    .adj_sec_pulse(adj_sec_pulse), .adj_min_pulse(adj_min_pulse), .adj_hrs_pulse(adj_hrs_pulse),
    .sec_u(sec_u), .sec_d(sec_d), .min_u(min_u), .min_d(min_d),
    .hrs_u(hrs_u), .hrs_d(hrs_d), .color_offset(color_offset), .sec_tick(sec_tick)
  );

  always #5 px_clk = ~px_clk;

`ifdef TIMEKEEPER_12H_EN
  localparam int HRS_RST = 12;
  localparam int HRS_TOP = 12;
  localparam int HRS_AFTER_WRAP = 1;
  function automatic int hour_next(input int h); return (h % 12) + 1; endfunction
`else
  localparam int HRS_RST = 0;
  localparam int HRS_TOP = 23;
  localparam int HRS_AFTER_WRAP = 0;
  function automatic int hour_next(input int h); return (h + 1) % 24; endfunction
`endif

  // Reference model: time kept as plain integers.
  int m_s, m_m, m_h, m_color, m_presc;
  bit m_pend, m_stick;

  task automatic model_edge(input bit r, input bit as, input bit am, input bit ah);
    bit tk, adj, app;
    if (r) begin
      m_presc = 0; m_pend = 0; m_stick = 0; m_color = 0;
      m_s = 0; m_m = 0; m_h = HRS_RST;
    end else begin
      tk = (m_presc == T - 1);
      m_presc = tk ? 0 : m_presc + 1;
      adj = as | am | ah;
      app = (tk | m_pend) & ~adj;
      m_pend = adj & (tk | m_pend);
      m_stick = app;
      if (app) begin
        m_s = m_s + 1;
        if (m_s == 60) begin
          m_s = 0;
          m_m = m_m + 1;
          m_color = (m_color + 1) % 16;
          if (m_m == 60) begin
            m_m = 0;
            m_h = hour_next(m_h);
          end
        end
      end else begin
        if (as) m_s = (m_s + 1) % 60;
        if (am) begin
          m_m = (m_m + 1) % 60;
          m_color = (m_color + 1) % 16;
        end
        if (ah) m_h = hour_next(m_h);
      end
    end
  endtask

  task automatic check(input string tag);
    logic [24:0] obs, expv;
    obs  = {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, color_offset, sec_tick};
    expv = {2'(m_h / 10), 4'(m_h % 10), 3'(m_m / 10), 4'(m_m % 10),
            3'(m_s / 10), 4'(m_s % 10), 4'(m_color), m_stick};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit r, input bit as, input bit am, input bit ah, input string tag);
    reset = r; adj_sec_pulse = as; adj_min_pulse = am; adj_hrs_pulse = ah;
    @(posedge px_clk);
    model_edge(r, as, am, ah);
    @(negedge px_clk);
    check(tag);
  endtask

  initial begin
    @(negedge px_clk);
    step(1, 0, 0, 0, "reset");
    step(1, 0, 0, 0, "reset");
    check_val("reset_state", {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, color_offset, sec_tick},
              {2'(HRS_RST / 10), 4'(HRS_RST % 10), 21'd0});

    // First second after reset, then the first minute rollover.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "first_sec");
    check_val("first_tick", {sec_d, sec_u, sec_tick}, {3'd0, 4'd1, 1'b1});
    step(0, 0, 0, 0, "tick_single");
    check_val("tick_one_cycle", {31'd0, sec_tick}, 32'd0);
    for (int i = 0; i < 235; i++) step(0, 0, 0, 0, "run_minute");
    check_val("one_minute", {min_d, min_u, sec_d, sec_u, color_offset}, {3'd0, 4'd1, 3'd0, 4'd0, 4'd1});

    // Preload top-of-day minus one second, then let the tick wrap everything.
    step(1, 0, 0, 0, "reset");
    for (int i = 0; i < 59; i++)
      step(0, i < 58, 1, i < ((HRS_TOP - HRS_RST + 24) % 24 == 0 ? 12 : (HRS_TOP - HRS_RST)),
           "preload");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "day_wrap");
    check_val("day_wrap_val", {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, sec_tick},
              {2'(HRS_AFTER_WRAP / 10), 4'(HRS_AFTER_WRAP % 10), 14'd0, 1'b1});

    // Seconds adjust wraps without carry.
    step(1, 0, 0, 0, "reset");
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0, "adj_sec_load");
    step(0, 1, 0, 0, "adj_sec_wrap");
    check_val("adj_sec_nocarry", {min_d, min_u, sec_d, sec_u, sec_tick}, 15'd0);
    step(0, 0, 0, 0, "pend_after_adj");

    // Minutes adjust wraps without carry and bumps the palette index.
    step(1, 0, 0, 0, "reset");
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0, "adj_min_load");
    step(0, 0, 1, 0, "adj_min_wrap");
    check_val("adj_min_nocarry", {hrs_d, hrs_u, min_d, min_u, color_offset},
              {2'(HRS_RST / 10), 4'(HRS_RST % 10), 7'd0, 4'd12});

    // Held minute adjust across a tick edge, tick lands right after.
    step(1, 0, 0, 0, "reset");
    step(0, 0, 0, 0, "hold_pre");
    step(0, 0, 0, 0, "hold_pre");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "hold_adj");
    check_val("hold_min3", {min_u, sec_u, sec_tick}, {4'd3, 4'd0, 1'b0});
    step(0, 0, 0, 0, "hold_land");
    check_val("pending_lands", {sec_u, sec_tick}, {4'd1, 1'b1});

    // Reset drops a pending tick at 05:30:20.
    step(1, 0, 0, 0, "reset");
    for (int i = 0; i < 30; i++) step(0, i < 20, 1, i < 5, "load_053020");
    check_val("at_053020", {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u}, {2'd0, 4'd5, 3'd3, 4'd0, 3'd2, 4'd0});
    step(1, 0, 0, 0, "reset_pending");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "no_late_tick");
    check_val("no_late_tick_val", {sec_u, sec_tick}, 32'd0);
    step(0, 0, 0, 0, "fresh_tick");

    // Randomized pulses, occasional resets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, "random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
